// File: rtl/opwb_writeback.sv
// rtl/opwb_writeback.sv - writeback stage: selects W[opcode], drives the register-file write port,
// sequences the two-write SWAP, keeps zero/carry flags, halts on TRAP and counts retired bundles.
module opwb_writeback #(
   parameter int DATA_W  = 20,
   parameter int NUM_OPS = 32,
   parameter int REG_AW  = 4,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [4:0]                opcode,
   input  logic [NUM_OPS*DATA_W-1:0] w_bus,
   input  logic [DATA_W-1:0]         swap_b,
   input  logic                      inc_carry,
   input  logic [REG_AW-1:0]         dest_a,
   input  logic [REG_AW-1:0]         dest_b,
   output logic                      rf_we,
   output logic [REG_AW-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   output logic                      flag_z,
   output logic                      flag_c,
   output logic                      illegal,
   output logic                      halted,
   output logic [CNT_W-1:0]          retire_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_ACT, S_SWAP1, S_SWAP2, S_HALT} state_t;
   typedef enum logic [2:0] {C_TRAP, C_NOWR, C_SINGLE, C_SWAP, C_ILL} op_class_t;

   state_t              state, state_n;
   op_class_t           op_class;
   logic                accept;
   logic [DATA_W-1:0]   w_slot [NUM_OPS];
   logic [DATA_W-1:0]   swap_b_q, swb_n;
   logic [REG_AW-1:0]   dest_b_q, dstb_n;
   logic                ready_n, we_n, z_n, c_n, ill_n, halt_n;
   logic [REG_AW-1:0]   waddr_n;
   logic [DATA_W-1:0]   wdata_n;
   logic [CNT_W-1:0]    cnt_n;

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_slot
      assign w_slot[k] = w_bus[k*DATA_W +: DATA_W];
   end

   assign accept = in_valid & in_ready;

   always_comb begin
      op_class = C_ILL;
      case (opcode)
         5'd0:                 op_class = C_TRAP;
         5'd1, 5'd2:           op_class = C_NOWR;
         5'd16:                op_class = C_SWAP;
         5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd17:
                               op_class = C_SINGLE;
         default:              op_class = C_ILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      we_n    = 1'b0;
      waddr_n = rf_waddr;
      wdata_n = rf_wdata;
      z_n     = flag_z;
      c_n     = flag_c;
      ill_n   = 1'b0;
      halt_n  = halted;
      cnt_n   = retire_cnt;
      dstb_n  = dest_b_q;
      swb_n   = swap_b_q;
      case (state)
         S_SWAP1: begin
            state_n = S_SWAP2;
            we_n    = 1'b1;
            waddr_n = dest_b_q;
            wdata_n = swap_b_q;
            z_n     = (swap_b_q == '0);
         end
         S_HALT: begin
         end
         default: begin
            if (accept) begin
               cnt_n = retire_cnt + CNT_W'(1);
               case (op_class)
                  C_SWAP: begin
                     state_n = S_SWAP1;
                     we_n    = 1'b1;
                     waddr_n = dest_a;
                     wdata_n = w_slot[16];
                     z_n     = (w_slot[16] == '0);
                     dstb_n  = dest_b;
                     swb_n   = swap_b;
                  end
                  C_TRAP: begin
                     state_n = S_HALT;
                     halt_n  = 1'b1;
                  end
                  C_SINGLE: begin
                     state_n = S_ACT;
                     we_n    = 1'b1;
                     waddr_n = dest_a;
                     wdata_n = w_slot[opcode];
                     z_n     = (w_slot[opcode] == '0);
                     if (opcode == 5'd17) c_n = inc_carry;
                  end
                  C_ILL: begin
                     state_n = S_ACT;
                     ill_n   = 1'b1;
                  end
                  default: state_n = S_ACT;
               endcase
            end else begin
               state_n = S_IDLE;
            end
         end
      endcase
      // ready is registered, so it is derived from where the FSM is going
      ready_n = (state_n != S_SWAP1) && (state_n != S_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready   <= 1'b0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         flag_z     <= 1'b0;
         flag_c     <= 1'b0;
         illegal    <= 1'b0;
         halted     <= 1'b0;
         retire_cnt <= '0;
         dest_b_q   <= '0;
         swap_b_q   <= '0;
      end else begin
         in_ready   <= ready_n;
         rf_we      <= we_n;
         rf_waddr   <= waddr_n;
         rf_wdata   <= wdata_n;
         flag_z     <= z_n;
         flag_c     <= c_n;
         illegal    <= ill_n;
         halted     <= halt_n;
         retire_cnt <= cnt_n;
         dest_b_q   <= dstb_n;
         swap_b_q   <= swb_n;
      end
   end

endmodule

// File: doc/opwb_writeback.md
Name: opwb_writeback

Overview:
- Writeback stage directly downstream of the per-opcode operation paths.
- Each accepted instruction carries the 5-bit opcode and the full set of per-opcode result buses. The stage selects W[opcode], registers it, and drives the register-file write port.
- Sequences the two-write SWAP (opcode 16). Updates zero/carry flags, halts on TRAP and counts retired instructions.

Parameters:
- DATA_W, 20, datapath width.
- NUM_OPS, 32, number of opcode slots (opcode width = 5).
- REG_AW, 4, register-file address width.
- CNT_W, 16, retire counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction/result bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- opcode  in  5  opcode of bundle.
- w_bus  in  NUM_OPS*DATA_W  flattened result buses; slot k = bits [k*DATA_W +: DATA_W].
- swap_b  in  DATA_W  second SWAP result.
- inc_carry  in  1  carry-out from the INC path.
- dest_a  in  REG_AW  primary destination register.
- dest_b  in  REG_AW  SWAP second destination register.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry flag.
- illegal  out  1  one-cycle pulse: unimplemented opcode retired.
- halted  out  1  TRAP retired; stage frozen.
- retire_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, flag_z=0, flag_c=0, illegal=0, halted=0, retire_cnt=0. in_ready goes high on the first edge after rst_n rises.
- Accept = in_valid & in_ready, sampled on the clk rising edge. All outputs are registered.
- Opcode classes:
  - Single write: 8–15, 17. Write W[opcode] to dest_a.
  - Double write: 16 (SWAP).
  - No write: 1 (NOP), 2 (JMP).
  - Halt: 0 (TRAP).
  - Illegal: all other codes.
- States:
  - IDLE
  - ACT: one output cycle for single-write, no-write or illegal.
  - SWAP1
  - SWAP2
  - HALT
- in_ready = state not in {SWAP1, HALT}.
- Transitions on accept from IDLE, ACT or SWAP2:
  - SWAP goes to SWAP1.
  - TRAP goes to HALT.
  - Any other opcode goes to ACT.
- Transitions without accept:
  - From ACT or SWAP2, go to IDLE.
  - SWAP1 always goes to SWAP2.
  - HALT stays in HALT until reset.
- Latency: an accept at edge N produces rf_we/rf_waddr/rf_wdata valid in the cycle after edge N.
  - Single-write ops sustain 1 bundle/cycle back-to-back.
  - SWAP occupies 2 output cycles, with in_ready low for 1 cycle.
- Write data:
  - ACT, single-write: rf_we=1, rf_waddr=dest_a, rf_wdata=W[opcode].
  - ACT, no-write or illegal: rf_we=0; rf_waddr and rf_wdata hold their previous values.
  - SWAP1: rf_we=1, rf_waddr=dest_a, rf_wdata=W[16].
  - SWAP2: rf_we=1, rf_waddr=dest_b, rf_wdata=swap_b. dest_b and swap_b are captured at accept, not re-sampled.
  - IDLE and HALT: rf_we=0.
- SWAP with dest_a==dest_b: both writes are issued; the final register value is swap_b.
- Flags:
  - flag_z is updated on every rf_we cycle to (rf_wdata==0). It is held otherwise, including NOP, JMP, illegal and TRAP.
  - flag_c is updated only when opcode 17 is accepted, to the captured inc_carry. It is held otherwise.
- illegal: high for exactly the ACT cycle of an illegal opcode.
- halted: set in the cycle after TRAP is accepted; cleared only by reset. In HALT, in_valid is ignored and nothing is written.
- retire_cnt:
  - Increments by 1 per accepted bundle, including NOP, JMP, illegal and TRAP.
  - SWAP counts once, at accept.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-SWAP (in SWAP1): outputs clear immediately, the second write is dropped, and state becomes IDLE.
- in_valid is sampled only when in_ready=1; an upstream stall inserts no writes.

Test Plan:
- Reset, then accept opcode 9 with W[9]=20'h0F0F0 and dest_a=3 → next cycle rf_we=1, rf_waddr=3, rf_wdata=0F0F0, flag_z=0, retire_cnt=1.
- Back-to-back opcode 11 (W=0, dest 1) then opcode 17 (W=20'h00000, inc_carry=1, dest 2) on consecutive cycles → writes in consecutive cycles; flag_z=1 after each; flag_c=1 after the second; in_ready stays high.
- SWAP with W[16]=20'hAAAAA, swap_b=20'h55555, dest_a=4, dest_b=5, with in_valid held high on the next bundle → write (4,AAAAA) then (5,55555); in_ready low for exactly one cycle; the next bundle is accepted on the SWAP2 edge; retire_cnt +1 for the SWAP.
- Opcode 1, then opcode 2, then opcode 5 → no rf_we; illegal pulses one cycle only for opcode 5; flag_z and flag_c unchanged; retire_cnt +3.
- TRAP, then opcode 9 presented with in_valid high → halted=1, in_ready=0, no further writes, retire_cnt frozen; asserting rst_n low clears everything asynchronously mid-cycle.
- Preload retire_cnt to FFFF via 65535 accepts (or force), then accept one NOP → retire_cnt=0000.
- Reset asserted during SWAP1 → rf_we drops immediately; no dest_b write occurs.
